hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Pipeline-control counterpart to the 5-stage RISC-V datapath.
- Consumes the datapath's register-address, write-enable, result-select and branch-taken status.
- Drives back StallF, StallD, FlushD, FlushE, ForwardAE and ForwardBE.
- Adds sequential control: a post-reset pipeline-flush sequence and a debug halt/drain handshake.

Parameters:
- RESET_FLUSH_CYCLES, 2, cycles after reset release during which F is held and D/E are flushed (legal range 1..15).
- HALT_DRAIN_CYCLES, 3, bubble cycles inserted before halt_ack asserts (empties E, M, W).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Rs1D  in  5  source 1 register, D stage (low 5 bits of datapath bus)
- Rs2D  in  5  source 2 register, D stage
- Rs1E  in  5  source 1 register, E stage
- Rs2E  in  5  source 2 register, E stage
- RdE  in  5  destination register, E stage
- ResultSrcE  in  2  result select in E; 01 = load
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM  in  5  destination register, M stage
- RegWriteM  in  1  register write enable, M stage
- RdW  in  5  destination register, W stage
- RegWriteW  in  1  register write enable, W stage
- halt_req  in  1  debug halt request, level
- StallF  out  1  1 = hold PC
- StallD  out  1  1 = hold IF/ID register
- FlushD  out  1  1 = clear IF/ID register
- FlushE  out  1  1 = clear ID/EX register
- ForwardAE  out  2  SrcA select: 00 register file, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  SrcB select, same encoding
- halt_ack  out  1  registered; pipeline halted and drained

Behaviour:
- Forwarding (combinational, all states), shown for A; B is identical with Rs2E:
  - 10 if RegWriteM & RdM==Rs1E & RdM!=0;
  - else 01 if RegWriteW & RdW==Rs1E & RdW!=0;
  - else 00.
  - M stage has priority over W.
- lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- FSM states: RST_FLUSH, RUN, HALT_DRAIN, HALTED. Registers are state, a 4-bit counter cnt, and halt_ack.
- Async reset: state=RST_FLUSH, cnt=RESET_FLUSH_CYCLES-1, halt_ack=0.
  - Forward outputs are 00 while datapath stage registers are reset, since their Rd/RegWrite values are 0.
- RST_FLUSH:
  - Outputs: StallF=1, StallD=0, FlushD=1, FlushE=1.
  - cnt decrements each cycle; at cnt==0 go to RUN.
  - halt_req is ignored in this state.
- RUN:
  - Outputs: StallF=lwStall&~PCSrcE, StallD=same, FlushD=PCSrcE, FlushE=PCSrcE|lwStall.
  - PCSrcE has priority over lwStall.
  - If halt_req & ~PCSrcE & ~lwStall, go to HALT_DRAIN with cnt=HALT_DRAIN_CYCLES-1.
  - Otherwise halt entry is deferred one cycle at a time until the flush or stall clears.
- HALT_DRAIN:
  - Outputs: StallF=1, StallD=1, FlushD=0, FlushE=1.
  - If halt_req drops, go to RUN next cycle; halt_ack is never asserted.
  - Else at cnt==0 go to HALTED and set halt_ack=1 on the same edge.
- HALTED:
  - Outputs same as HALT_DRAIN; halt_ack=1.
  - When halt_req drops, go to RUN and clear halt_ack on the same edge.
- Reset asserted in any state returns immediately to RST_FLUSH.
- Stall and flush outputs are decoded combinationally from state plus inputs; there is no added latency.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds two output ports, each a 32-bit free-running counter:
  - stall_cycles: increments when StallD=1 in RUN.
  - flush_events: increments when PCSrcE=1 in RUN.
- Both reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent.

Decomposition:
- Package hazard_pkg holds:
  - FSM state enum;
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RESULT_SRC_LOAD=2'b01.
- Sub-module hazard_fwd_sel: combinational, taking rs, RdM, RegWriteM, RdW, RegWriteW and producing a 2-bit select. It is instantiated twice (A and B).

Test Plan:
- Reset held 3 cycles, then released with RESET_FLUSH_CYCLES=2 -> StallF/FlushD/FlushE=1 for exactly 2 cycles after release, then all 0 in RUN.
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. With RdM=0 and RdW=5 -> ForwardAE=01.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle. With RdE=0 -> no stall.
- PCSrcE=1 together with a load-use match -> FlushD=FlushE=1, StallF=StallD=0.
- halt_req rises in RUN with no hazard -> 3 cycles of StallF/StallD/FlushE, then halt_ack=1. halt_req falls -> halt_ack=0 and RUN on the next edge. A drop during drain -> halt_ack is never asserted.
- With HAZARD_PERF_CNT_EN: 4 load-use stalls and 2 taken branches -> stall_cycles=4, flush_events=2. Reset mid-run -> both 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
// Holds FSM state codes, forwarding selects and result-select codes.
package hazard_pkg;

    // FSM state codes
    typedef logic [1:0] hz_state_t;
    localparam hz_state_t ST_RST_FLUSH  = 2'd0;
    localparam hz_state_t ST_RUN        = 2'd1;
    localparam hz_state_t ST_HALT_DRAIN = 2'd2;
    localparam hz_state_t ST_HALTED     = 2'd3;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // ResultSrc code of a load
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Datapath <-> hazard controller bundle.
// HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface hazard_ctrl_unit_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [1:0] ResultSrcE;
    logic       PCSrcE;
    logic [4:0] RdM;
    logic       RegWriteM;
    logic [4:0] RdW;
    logic       RegWriteW;
    logic       halt_req;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       halt_ack;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        output RdM, RegWriteM, RdW, RegWriteW, halt_req,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles, flush_events,
`endif
        input  StallF, StallD, FlushD, FlushE,
        input  ForwardAE, ForwardBE, halt_ack
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        input  RdM, RegWriteM, RdW, RegWriteW, halt_req,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles, flush_events,
`endif
        output StallF, StallD, FlushD, FlushE,
        output ForwardAE, ForwardBE, halt_ack
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage source operand.
// M-stage result has priority over W-stage result; x0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] RdM_i,
    input  logic       RegWriteM_i,
    input  logic [4:0] RdW_i,
    input  logic       RegWriteW_i,
    output logic [1:0] sel_o
);

    // Pick the youngest in-flight producer of rs
    always_comb begin
        sel_o = FWD_RF;
        if (RegWriteM_i && (RdM_i == rs_i) && (RdM_i != 5'd0))
            sel_o = FWD_M;
        else if (RegWriteW_i && (RdW_i == rs_i) && (RdW_i != 5'd0))
            sel_o = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: forwarding, load-use stall, branch flush,
// post-reset flush and debug halt/drain. Macro: HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RESET_FLUSH_CYCLES = 2,
    parameter int unsigned HALT_DRAIN_CYCLES  = 3
)(
    input logic              clk,
    input logic              rst,
    hazard_ctrl_unit_if.slave hz
);

    localparam logic [3:0] RST_CNT   = 4'(RESET_FLUSH_CYCLES - 1);
    localparam logic [3:0] DRAIN_CNT = 4'(HALT_DRAIN_CYCLES - 1);

    hz_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ack_q, ack_d;
    logic       lw_stall;

    hazard_fwd_sel u_fwd_a (
        .rs_i        (hz.Rs1E),
        .RdM_i       (hz.RdM),
        .RegWriteM_i (hz.RegWriteM),
        .RdW_i       (hz.RdW),
        .RegWriteW_i (hz.RegWriteW),
        .sel_o       (hz.ForwardAE)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_i        (hz.Rs2E),
        .RdM_i       (hz.RdM),
        .RegWriteM_i (hz.RegWriteM),
        .RdW_i       (hz.RdW),
        .RegWriteW_i (hz.RegWriteW),
        .sel_o       (hz.ForwardBE)
    );

    assign lw_stall = (hz.ResultSrcE == RESULT_SRC_LOAD)
                    && (hz.RdE != 5'd0)
                    && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Stall/flush decode from state and live hazards
    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        unique case (state_q)
            ST_RST_FLUSH: begin
                hz.StallF = 1'b1;
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
            end
            ST_RUN: begin
                hz.StallF = lw_stall & ~hz.PCSrcE;
                hz.StallD = lw_stall & ~hz.PCSrcE;
                hz.FlushD = hz.PCSrcE;
                hz.FlushE = hz.PCSrcE | lw_stall;
            end
            ST_HALT_DRAIN, ST_HALTED: begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state: reset flush, run, halt drain, halted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        unique case (state_q)
            ST_RST_FLUSH: begin
                if (cnt_q == 4'd0) state_d = ST_RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RUN: begin
                if (hz.halt_req && !hz.PCSrcE && !lw_stall) begin
                    state_d = ST_HALT_DRAIN;
                    cnt_d   = DRAIN_CNT;
                end
            end
            ST_HALT_DRAIN: begin
                if (!hz.halt_req) begin
                    state_d = ST_RUN;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                if (!hz.halt_req) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_RST_FLUSH;
                cnt_d   = RST_CNT;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RST_FLUSH;
            cnt_q   <= RST_CNT;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign hz.halt_ack = ack_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Free-running RUN-state stall and branch-flush counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else if (state_q == ST_RUN) begin
            if (hz.StallD) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (hz.PCSrcE) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed literals
// followed by randomized traffic against a behavioural model.
module tb_hazard_ctrl_unit;

    localparam int RFC = 2;
    localparam int HDC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_unit_if bus();

    hazard_ctrl_unit #(
        .RESET_FLUSH_CYCLES (RFC),
        .HALT_DRAIN_CYCLES  (HDC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int    m_rf_left;
    int    m_drain_left;
    bit    m_halted;
    bit    m_ack;
    longint m_stalls;
    longint m_flushes;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (bus.RegWriteM && bus.RdM == rs && bus.RdM != 0) return 2'b10;
        if (bus.RegWriteW && bus.RdW == rs && bus.RdW != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit lw();
        return bus.ResultSrcE == 2'b01 && bus.RdE != 0 &&
               (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    endfunction

    task automatic mdl_reset();
        m_rf_left    = RFC;
        m_drain_left = 0;
        m_halted     = 0;
        m_ack        = 0;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    task automatic mdl_step();
        if (m_rf_left > 0) begin
            m_rf_left--;
        end else if (m_halted) begin
            if (!bus.halt_req) begin
                m_halted = 0;
                m_ack    = 0;
            end
        end else if (m_drain_left > 0) begin
            if (!bus.halt_req) m_drain_left = 0;
            else begin
                m_drain_left--;
                if (m_drain_left == 0) begin
                    m_halted = 1;
                    m_ack    = 1;
                end
            end
        end else begin
            if (lw() && !bus.PCSrcE) m_stalls++;
            if (bus.PCSrcE) m_flushes++;
            if (bus.halt_req && !bus.PCSrcE && !lw())
                m_drain_left = HDC;
        end
    endtask

    task automatic mdl_compare();
        bit sf, sd, fd, fe;
        if (m_rf_left > 0) begin
            sf = 1; sd = 0; fd = 1; fe = 1;
        end else if (m_halted || m_drain_left > 0) begin
            sf = 1; sd = 1; fd = 0; fe = 1;
        end else begin
            sf = lw() && !bus.PCSrcE;
            sd = sf;
            fd = bus.PCSrcE;
            fe = bus.PCSrcE || lw();
        end
        chk("m_StallF", 32'(bus.StallF), 32'(sf));
        chk("m_StallD", 32'(bus.StallD), 32'(sd));
        chk("m_FlushD", 32'(bus.FlushD), 32'(fd));
        chk("m_FlushE", 32'(bus.FlushE), 32'(fe));
        chk("m_FwdA", 32'(bus.ForwardAE), 32'(fwd(bus.Rs1E)));
        chk("m_FwdB", 32'(bus.ForwardBE), 32'(fwd(bus.Rs2E)));
        chk("m_ack", 32'(bus.halt_ack), 32'(m_ack));
`ifdef HAZARD_PERF_CNT_EN
        chk("m_stalls", bus.stall_cycles, 32'(m_stalls));
        chk("m_flushes", bus.flush_events, 32'(m_flushes));
`endif
    endtask

    // model compare process: check at negedge, advance at posedge
    initial begin
        mdl_reset();
        forever begin
            @(negedge clk);
            if (rst) mdl_reset();
            mdl_compare();
            @(posedge clk);
            if (!rst) mdl_step();
        end
    end

    task automatic zero_in();
        bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
        bus.RdE = 0; bus.ResultSrcE = 0; bus.PCSrcE = 0;
        bus.RdM = 0; bus.RegWriteM = 0;
        bus.RdW = 0; bus.RegWriteW = 0;
        bus.halt_req = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        zero_in();
        // reset held 3 cycles, then 2 flush cycles
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rf_StallF", 32'(bus.StallF), 32'd1);
            chk("rf_FlushD", 32'(bus.FlushD), 32'd1);
            chk("rf_FlushE", 32'(bus.FlushE), 32'd1);
        end
        @(negedge clk);
        chk("run_StallF", 32'(bus.StallF), 32'd0);
        chk("run_FlushE", 32'(bus.FlushE), 32'd0);

        // forwarding
        nxt();
        bus.RegWriteM = 1; bus.RdM = 5;
        bus.RegWriteW = 1; bus.RdW = 5;
        bus.Rs1E = 5; bus.Rs2E = 0;
        @(negedge clk);
        chk("fwd_AE_M", 32'(bus.ForwardAE), 32'd2);
        chk("fwd_BE_x0", 32'(bus.ForwardBE), 32'd0);
        nxt();
        bus.RdM = 0;
        @(negedge clk);
        chk("fwd_AE_W", 32'(bus.ForwardAE), 32'd1);

        // load-use
        nxt();
        zero_in();
        bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7;
        @(negedge clk);
        chk("lu_StallF", 32'(bus.StallF), 32'd1);
        chk("lu_StallD", 32'(bus.StallD), 32'd1);
        chk("lu_FlushE", 32'(bus.FlushE), 32'd1);
        nxt();
        bus.RdE = 0;
        @(negedge clk);
        chk("lu_x0_StallF", 32'(bus.StallF), 32'd0);

        // branch beats load-use
        nxt();
        bus.RdE = 7; bus.PCSrcE = 1;
        @(negedge clk);
        chk("br_FlushD", 32'(bus.FlushD), 32'd1);
        chk("br_FlushE", 32'(bus.FlushE), 32'd1);
        chk("br_StallF", 32'(bus.StallF), 32'd0);
        chk("br_StallD", 32'(bus.StallD), 32'd0);

        // halt with drain
        nxt();
        zero_in();
        bus.halt_req = 1;
        @(negedge clk);
        chk("h_run_StallF", 32'(bus.StallF), 32'd0);
        repeat (HDC) begin
            @(negedge clk);
            chk("h_drain_StallD", 32'(bus.StallD), 32'd1);
            chk("h_drain_ack", 32'(bus.halt_ack), 32'd0);
        end
        @(negedge clk);
        chk("h_ack", 32'(bus.halt_ack), 32'd1);
        chk("h_halt_StallF", 32'(bus.StallF), 32'd1);
        nxt();
        bus.halt_req = 0;
        @(negedge clk);
        chk("h_ack_hold", 32'(bus.halt_ack), 32'd1);
        @(negedge clk);
        chk("h_ack_clr", 32'(bus.halt_ack), 32'd0);
        chk("h_resume", 32'(bus.StallF), 32'd0);

        // halt dropped mid-drain
        nxt();
        bus.halt_req = 1;
        @(negedge clk);
        @(negedge clk);
        nxt();
        bus.halt_req = 0;
        @(negedge clk);
        chk("d_drain", 32'(bus.StallF), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("d_noack", 32'(bus.halt_ack), 32'd0);
        end
        chk("d_run", 32'(bus.StallF), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst = ($urandom_range(0, 249) == 0);
            bus.Rs1D = 5'($urandom_range(0, 3));
            bus.Rs2D = 5'($urandom_range(0, 3));
            bus.Rs1E = 5'($urandom_range(0, 3));
            bus.Rs2E = 5'($urandom_range(0, 3));
            bus.RdE  = 5'($urandom_range(0, 3));
            bus.RdM  = 5'($urandom_range(0, 3));
            bus.RdW  = 5'($urandom_range(0, 3));
            bus.ResultSrcE = 2'($urandom_range(0, 3));
            bus.PCSrcE    = ($urandom_range(0, 5) == 0);
            bus.RegWriteM = 1'($urandom_range(0, 1));
            bus.RegWriteW = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 14) == 0)
                bus.halt_req = ~bus.halt_req;
        end
        nxt();
        rst = 0;
        zero_in();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
